// File: rtl/pipe_pkg.sv
// Shared pipeline-stage types: IF/ID payload layout, the NOP bubble it carries
// while empty, and the payload widths of every inter-stage register.
`timescale 1ns/1ps
package pipe_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        br_sel_btb;
        logic [31:0] predicted_pc;
    } if_id_payload_t;

    localparam int IF_ID_W  = $bits(if_id_payload_t);
    localparam int ID_EX_W  = 160;
    localparam int EX_MEM_W = 110;
    localparam int MEM_WB_W = 72;

    localparam if_id_payload_t IF_ID_BUBBLE = '{
        pc:           32'h0000_0000,
        instr:        NOP_INSTR,
        br_sel_btb:   1'b0,
        predicted_pc: 32'h0000_0000
    };

endpackage

// File: rtl/pipe_skid_stage.sv
// Valid/ready pipeline register with flush-to-bubble, optional 2-entry skid
// buffer (fully registered upstream ready) and a saturating stall counter.
`timescale 1ns/1ps
module pipe_skid_stage
    import pipe_pkg::*;
#(
    parameter int                 DATA_W     = IF_ID_W,
    parameter logic [DATA_W-1:0]  BUBBLE_VAL = IF_ID_BUBBLE,
    parameter bit                 SKID_EN    = 1'b1,
    parameter int                 CNT_W      = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    logic              main_v_q;
    logic              main_v_d;
    logic [DATA_W-1:0] main_data_q;
    logic [DATA_W-1:0] main_data_d;
    logic [CNT_W-1:0]  stall_q;
    logic [CNT_W-1:0]  stall_d;
    logic              in_xfer_s;
    logic              out_xfer_s;

    assign in_xfer_s   = in_valid_i & in_ready_o;
    assign out_xfer_s  = main_v_q & out_ready_i;
    assign out_valid_o = main_v_q;
    assign out_data_o  = main_data_q;
    assign stall_cnt_o = stall_q;

    // Stall counter next state: saturates, only reset clears it
    always_comb begin
        stall_d = stall_q;
        if (main_v_q && !out_ready_i && (stall_q != {CNT_W{1'b1}})) begin
            stall_d = stall_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            stall_d = stall_q;
        end
    end

    // Main output register and stall counter state
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            main_v_q    <= 1'b0;
            main_data_q <= BUBBLE_VAL;
            stall_q     <= {CNT_W{1'b0}};
        end else begin
            main_v_q    <= main_v_d;
            main_data_q <= main_data_d;
            stall_q     <= stall_d;
        end
    end

    generate
        if (SKID_EN) begin : g_skid
            logic              skid_v_q;
            logic              skid_v_d;
            logic [DATA_W-1:0] skid_data_q;
            logic [DATA_W-1:0] skid_data_d;

            // Ready comes straight from a flop, so out_ready_i never reaches upstream
            assign in_ready_o = ~skid_v_q;

            // Occupancy transitions over (main_v, skid_v)
            always_comb begin
                main_v_d    = main_v_q;
                main_data_d = main_data_q;
                skid_v_d    = skid_v_q;
                skid_data_d = skid_data_q;
                if (flush_i) begin
                    main_v_d    = 1'b0;
                    main_data_d = BUBBLE_VAL;
                    skid_v_d    = 1'b0;
                    skid_data_d = BUBBLE_VAL;
                end else begin
                    case ({main_v_q, skid_v_q})
                        2'b00: begin
                            if (in_xfer_s) begin
                                main_v_d    = 1'b1;
                                main_data_d = in_data_i;
                            end else begin
                                main_v_d    = 1'b0;
                            end
                        end
                        2'b10: begin
                            if (out_xfer_s && in_xfer_s) begin
                                main_data_d = in_data_i;
                            end else if (out_xfer_s) begin
                                main_v_d    = 1'b0;
                                main_data_d = BUBBLE_VAL;
                            end else if (in_xfer_s) begin
                                skid_v_d    = 1'b1;
                                skid_data_d = in_data_i;
                            end else begin
                                main_v_d    = 1'b1;
                            end
                        end
                        2'b11: begin
                            if (out_xfer_s) begin
                                main_data_d = skid_data_q;
                                skid_v_d    = 1'b0;
                                skid_data_d = BUBBLE_VAL;
                            end else begin
                                skid_v_d    = 1'b1;
                            end
                        end
                        default: begin
                            main_v_d    = 1'b0;
                            main_data_d = BUBBLE_VAL;
                            skid_v_d    = 1'b0;
                            skid_data_d = BUBBLE_VAL;
                        end
                    endcase
                end
            end

            // Skid entry state
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    skid_v_q    <= 1'b0;
                    skid_data_q <= BUBBLE_VAL;
                end else begin
                    skid_v_q    <= skid_v_d;
                    skid_data_q <= skid_data_d;
                end
            end
        end else begin : g_single
            assign in_ready_o = ~main_v_q | out_ready_i;

            // Single register: refill on accept, drain to bubble otherwise
            always_comb begin
                main_v_d    = main_v_q;
                main_data_d = main_data_q;
                if (flush_i) begin
                    main_v_d    = 1'b0;
                    main_data_d = BUBBLE_VAL;
                end else if (in_xfer_s) begin
                    main_v_d    = 1'b1;
                    main_data_d = in_data_i;
                end else if (out_xfer_s) begin
                    main_v_d    = 1'b0;
                    main_data_d = BUBBLE_VAL;
                end else begin
                    main_v_d    = main_v_q;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Directed and scoreboard-checked bench for pipe_skid_stage in skid, single-register
// and narrow-counter configurations.
`timescale 1ns/1ps
module tb_pipe_skid_stage;
    import pipe_pkg::*;

    localparam logic [96:0] BUB = {32'h0000_0000, 32'h0000_0013, 1'b0, 32'h0000_0000};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [96:0] in_data = BUB;
    logic        out_ready = 1'b0;
    logic        in_ready, out_valid;
    logic [96:0] out_data;
    logic [15:0] stall;
    logic        in_ready_c4, out_valid_c4;
    logic [96:0] out_data_c4;
    logic [3:0]  stall_c4;
    logic        ns_in_valid = 1'b0;
    logic [96:0] ns_in_data = BUB;
    logic        ns_out_ready = 1'b0;
    logic        ns_in_ready, ns_out_valid;
    logic [96:0] ns_out_data;
    logic [15:0] ns_stall;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    pipe_skid_stage dut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
        .stall_cnt_o(stall)
    );

    pipe_skid_stage #(.CNT_W(4)) dut_c4 (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .in_valid_i(in_valid), .in_ready_o(in_ready_c4), .in_data_i(in_data),
        .out_valid_o(out_valid_c4), .out_ready_i(out_ready), .out_data_o(out_data_c4),
        .stall_cnt_o(stall_c4)
    );

    pipe_skid_stage #(.SKID_EN(1'b0)) dut_ns (
        .clk_i(clk), .rst_i(rst), .flush_i(1'b0),
        .in_valid_i(ns_in_valid), .in_ready_o(ns_in_ready), .in_data_i(ns_in_data),
        .out_valid_o(ns_out_valid), .out_ready_i(ns_out_ready), .out_data_o(ns_out_data),
        .stall_cnt_o(ns_stall)
    );

    function automatic logic [96:0] mk(input logic [31:0] pc);
        if_id_payload_t p;
        p.pc           = pc;
        p.instr        = {pc[15:0], 16'h0033};
        p.br_sel_btb   = pc[2];
        p.predicted_pc = pc + 32'd4;
        return p;
    endfunction

    task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Drive main/c4 inputs for one cycle; outputs observed 1ns after the falling edge
    task automatic cyc(input logic v, input logic [31:0] pc, input logic rdy, input logic fl);
        @(negedge clk);
        in_valid  = v;
        in_data   = mk(pc);
        out_ready = rdy;
        flush     = fl;
        #1;
    endtask

    task automatic ncyc(input logic v, input logic [31:0] pc, input logic rdy);
        @(negedge clk);
        ns_in_valid  = v;
        ns_in_data   = mk(pc);
        ns_out_ready = rdy;
        #1;
    endtask

    logic [96:0] q[$];
    logic [15:0] m_stall;
    logic [3:0]  m_stall4;
    logic        exp_v, exp_rdy, ix, ox;
    logic [96:0] exp_d;
    logic [31:0] seq;

    initial begin
        // T1 reset
        cyc(1'b0, 32'h0, 1'b0, 1'b0);
        cyc(1'b0, 32'h0, 1'b0, 1'b0);
        check_eq("rst_valid", 128'(out_valid), 128'(1'b0));
        check_eq("rst_instr", 128'(out_data[64:33]), 128'(32'h0000_0013));
        check_eq("rst_data", 128'(out_data), 128'(BUB));
        check_eq("rst_ready", 128'(in_ready), 128'(1'b1));
        check_eq("rst_stall", 128'(stall), 128'(16'd0));
        rst = 1'b0;

        // T2 streaming, 1-cycle latency, no bubbles
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, 32'(i * 4), 1'b1, 1'b0);
            if (i == 0) begin
                check_eq("stream_first_empty", 128'(out_valid), 128'(1'b0));
            end else begin
                check_eq("stream_valid", 128'(out_valid), 128'(1'b1));
                check_eq("stream_data", 128'(out_data), 128'(mk(32'((i - 1) * 4))));
            end
        end
        cyc(1'b0, 32'h0, 1'b1, 1'b0);
        check_eq("stream_last", 128'(out_data), 128'(mk(32'h1C)));
        cyc(1'b0, 32'h0, 1'b1, 1'b0);
        check_eq("stream_drain_v", 128'(out_valid), 128'(1'b0));
        check_eq("stream_drain_d", 128'(out_data), 128'(BUB));
        check_eq("stream_stall", 128'(stall), 128'(16'd0));

        // T3 backpressure into skid
        cyc(1'b1, 32'h100, 1'b1, 1'b0);
        cyc(1'b1, 32'h104, 1'b0, 1'b0);
        check_eq("bp_ready_full", 128'(in_ready), 128'(1'b1));
        check_eq("bp_out100", 128'(out_data), 128'(mk(32'h100)));
        cyc(1'b1, 32'h108, 1'b0, 1'b0);
        check_eq("bp_ready_skid", 128'(in_ready), 128'(1'b0));
        check_eq("bp_hold100", 128'(out_data), 128'(mk(32'h100)));
        cyc(1'b1, 32'h108, 1'b0, 1'b0);
        check_eq("bp_stall2", 128'(stall), 128'(16'd2));
        cyc(1'b1, 32'h108, 1'b1, 1'b0);
        check_eq("bp_rel_100", 128'(out_data), 128'(mk(32'h100)));
        check_eq("bp_rel_ready", 128'(in_ready), 128'(1'b0));
        check_eq("bp_stall3", 128'(stall), 128'(16'd3));
        cyc(1'b1, 32'h108, 1'b1, 1'b0);
        check_eq("bp_out104", 128'(out_data), 128'(mk(32'h104)));
        check_eq("bp_ready_back", 128'(in_ready), 128'(1'b1));
        cyc(1'b0, 32'h0, 1'b1, 1'b0);
        check_eq("bp_out108", 128'(out_data), 128'(mk(32'h108)));
        check_eq("bp_v108", 128'(out_valid), 128'(1'b1));
        cyc(1'b0, 32'h0, 1'b1, 1'b0);
        check_eq("bp_empty", 128'(out_valid), 128'(1'b0));
        check_eq("bp_stall_final", 128'(stall), 128'(16'd3));

        // T4 flush while in SKID with a concurrent upstream beat
        cyc(1'b1, 32'h1F0, 1'b0, 1'b0);
        cyc(1'b1, 32'h1F4, 1'b0, 1'b0);
        cyc(1'b1, 32'h200, 1'b0, 1'b1);
        check_eq("fl_in_skid", 128'(in_ready), 128'(1'b0));
        check_eq("fl_pre_out", 128'(out_data), 128'(mk(32'h1F0)));
        cyc(1'b0, 32'h0, 1'b1, 1'b0);
        check_eq("fl_valid", 128'(out_valid), 128'(1'b0));
        check_eq("fl_instr", 128'(out_data[64:33]), 128'(32'h0000_0013));
        check_eq("fl_ready", 128'(in_ready), 128'(1'b1));
        check_eq("fl_stall_kept", 128'(stall), 128'(16'd5));
        check_eq("fl_stall_c4", 128'(stall_c4), 128'(4'd5));
        cyc(1'b1, 32'h300, 1'b1, 1'b1);
        cyc(1'b0, 32'h0, 1'b1, 1'b0);
        check_eq("fl_drop_inxfer", 128'(out_valid), 128'(1'b0));
        cyc(1'b0, 32'h0, 1'b1, 1'b0);
        check_eq("fl_never_emit", 128'(out_valid), 128'(1'b0));

        // Reset while in SKID: both entries lost
        cyc(1'b1, 32'h500, 1'b0, 1'b0);
        cyc(1'b1, 32'h504, 1'b0, 1'b0);
        cyc(1'b0, 32'h0, 1'b0, 1'b0);
        check_eq("rs_skid_full", 128'(in_ready), 128'(1'b0));
        rst = 1'b1;
        cyc(1'b0, 32'h0, 1'b1, 1'b0);
        rst = 1'b0;
        check_eq("rs_valid", 128'(out_valid), 128'(1'b0));
        check_eq("rs_ready", 128'(in_ready), 128'(1'b1));
        check_eq("rs_stall", 128'(stall), 128'(16'd0));
        cyc(1'b0, 32'h0, 1'b1, 1'b0);
        check_eq("rs_no_skid", 128'(out_valid), 128'(1'b0));

        // T5 single-register variant: combinational ready, no loss
        ncyc(1'b1, 32'h400, 1'b1);
        check_eq("ns_ready_empty", 128'(ns_in_ready), 128'(1'b1));
        ncyc(1'b1, 32'h404, 1'b0);
        check_eq("ns_ready_block", 128'(ns_in_ready), 128'(1'b0));
        check_eq("ns_out400", 128'(ns_out_data), 128'(mk(32'h400)));
        ncyc(1'b1, 32'h404, 1'b1);
        check_eq("ns_ready_pass", 128'(ns_in_ready), 128'(1'b1));
        check_eq("ns_hold400", 128'(ns_out_data), 128'(mk(32'h400)));
        ncyc(1'b1, 32'h408, 1'b0);
        check_eq("ns_out404", 128'(ns_out_data), 128'(mk(32'h404)));
        check_eq("ns_ready_block2", 128'(ns_in_ready), 128'(1'b0));
        ncyc(1'b1, 32'h408, 1'b1);
        check_eq("ns_hold404", 128'(ns_out_data), 128'(mk(32'h404)));
        ncyc(1'b0, 32'h0, 1'b1);
        check_eq("ns_out408", 128'(ns_out_data), 128'(mk(32'h408)));
        ncyc(1'b0, 32'h0, 1'b1);
        check_eq("ns_empty_v", 128'(ns_out_valid), 128'(1'b0));
        check_eq("ns_empty_d", 128'(ns_out_data), 128'(BUB));
        check_eq("ns_stall", 128'(ns_stall), 128'(16'd2));

        // T6 random valid/ready/flush against a queue model
        rst = 1'b1;
        cyc(1'b0, 32'h0, 1'b0, 1'b0);
        rst = 1'b0;
        q.delete();
        m_stall  = 16'd0;
        m_stall4 = 4'd0;
        seq      = 32'd0;
        for (int i = 0; i < 3000; i++) begin
            cyc(1'($urandom_range(0, 1)), seq * 32'd4, 1'($urandom_range(0, 9) < 6),
                1'($urandom_range(0, 39) == 0));
            exp_v   = (q.size() != 0);
            exp_rdy = (q.size() < 2);
            exp_d   = exp_v ? q[0] : BUB;
            check_eq("rnd_valid", 128'(out_valid), 128'(exp_v));
            check_eq("rnd_data", 128'(out_data), 128'(exp_d));
            check_eq("rnd_ready", 128'(in_ready), 128'(exp_rdy));
            check_eq("rnd_stall", 128'(stall), 128'(m_stall));
            check_eq("rnd_c4_data", 128'(out_data_c4), 128'(exp_d));
            check_eq("rnd_c4_ready", 128'(in_ready_c4), 128'(exp_rdy));
            check_eq("rnd_c4_stall", 128'(stall_c4), 128'(m_stall4));
            ix = in_valid && exp_rdy;
            ox = exp_v && out_ready;
            if (exp_v && !out_ready) begin
                if (m_stall != 16'hFFFF) m_stall = m_stall + 16'd1;
                if (m_stall4 != 4'hF) m_stall4 = m_stall4 + 4'd1;
            end
            if (ox) void'(q.pop_front());
            if (flush) begin
                q.delete();
            end else if (ix) begin
                q.push_back(in_data);
                seq = seq + 32'd1;
            end
        end
        check_eq("sat_c4", 128'(stall_c4), 128'(4'hF));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
